// File: rtl/uart_rx_ctrl_pkg.sv
// Shared definitions for the UART receive path: state encoding, default
// widths and the sample-point helper used by the controller.
package uart_rx_ctrl_pkg;

  localparam int unsigned DATA_WIDTH_DEF     = 8;
  localparam int unsigned PRESCALE_WIDTH_DEF = 5;
  localparam int unsigned STATE_W            = 3;

  // Frame sequencing states, 3-bit binary.
  typedef enum logic [STATE_W-1:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  // First oversample edge at which the sampler and checker results are
  // settled: (Prescale/2) + 3. With Prescale=8 this is the last edge of the
  // bit, which is legal.
  function automatic int unsigned sample_edge(input int unsigned prescale);
    return (prescale >> 1) + 3;
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversample edge counter and data-bit counter for the UART receiver.
// Edge counter wraps at Prescale-1; bit counter wraps after DATA_WIDTH-1.
// Clear has priority over increment on both counters.
module uart_rx_edge_bit_cnt
  import uart_rx_ctrl_pkg::*;
#(
  parameter int unsigned PRESCALE_WIDTH = PRESCALE_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEF,
  localparam int unsigned BIT_W         = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [PRESCALE_WIDTH-1:0] prescale_i,
  input  logic                      edge_en_i,
  input  logic                      edge_clr_i,
  input  logic                      bit_inc_i,
  input  logic                      bit_clr_i,
  output logic [PRESCALE_WIDTH-1:0] edge_cnt_o,
  output logic [BIT_W-1:0]          bit_cnt_o,
  output logic                      edge_last_o,
  output logic                      bit_last_o
);

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  logic [PRESCALE_WIDTH-1:0] edge_q, edge_d;
  logic [BIT_W-1:0]          bit_q, bit_d;

  assign edge_last_o = (edge_q == (prescale_i - 1'b1));
  assign bit_last_o  = (bit_q == BIT_LAST);
  assign edge_cnt_o  = edge_q;
  assign bit_cnt_o   = bit_q;

  // Next-count logic for both counters.
  always_comb begin
    edge_d = edge_q;
    bit_d  = bit_q;

    if (edge_clr_i) begin
      edge_d = '0;
    end else if (edge_en_i) begin
      if (edge_last_o) edge_d = '0;
      else             edge_d = edge_q + 1'b1;
    end

    if (bit_clr_i) begin
      bit_d = '0;
    end else if (bit_inc_i) begin
      if (bit_last_o) bit_d = '0;
      else            bit_d = bit_q + 1'b1;
    end
  end

  // Counter registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_q <= '0;
      bit_q  <= '0;
    end else begin
      edge_q <= edge_d;
      bit_q  <= bit_d;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencing controller. Detects the start edge, walks the
// frame through START/DATA/PARITY/STOP, drives the sampler/checker/
// deserializer enables and qualifies the word with a one-cycle Data_Valid.
//
// Handshake: there is no back-pressure. Deser_En is a one-cycle strobe per
// data bit, and Data_Valid is a one-cycle pulse in the first IDLE cycle after
// a frame whose parity and stop checks both passed; the consumer must take
// the word in that cycle.
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int unsigned PRESCALE_WIDTH = PRESCALE_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEF,
  localparam int unsigned BIT_W         = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic                      PAR_EN,
  input  logic                      Strt_Glitch,
  input  logic                      Par_Err,
  input  logic                      Stp_Err,
  output logic [PRESCALE_WIDTH-1:0] Edge_Cnt,
  output logic [BIT_W-1:0]          Bit_Cnt,
  output logic                      Dat_Samp_En,
  output logic                      Strt_Chk_En,
  output logic                      Par_Chk_En,
  output logic                      Stp_Chk_En,
  output logic                      Deser_En,
  output logic                      Data_Valid,
  output logic                      Busy,
  output logic [STATE_W-1:0]        State_Dbg
);

  rx_state_e state_q, state_d;

  logic par_en_q, par_en_d;
  logic err_q, err_d;
  logic dv_q, dv_d;
  logic busy_q, busy_d;

  logic edge_en, edge_clr, bit_inc, bit_clr;
  logic edge_last, bit_last;

  logic [PRESCALE_WIDTH-1:0] sample_pt;

  // Edge at which the deserializer shift strobe fires.
  assign sample_pt = PRESCALE_WIDTH'(sample_edge(32'(Prescale)));

  uart_rx_edge_bit_cnt #(
    .PRESCALE_WIDTH (PRESCALE_WIDTH),
    .DATA_WIDTH     (DATA_WIDTH)
  ) u_cnt (
    .CLK         (CLK),
    .RST         (RST),
    .prescale_i  (Prescale),
    .edge_en_i   (edge_en),
    .edge_clr_i  (edge_clr),
    .bit_inc_i   (bit_inc),
    .bit_clr_i   (bit_clr),
    .edge_cnt_o  (Edge_Cnt),
    .bit_cnt_o   (Bit_Cnt),
    .edge_last_o (edge_last),
    .bit_last_o  (bit_last)
  );

  // Next-state, counter control and enable decode from state and counters.
  always_comb begin
    state_d     = state_q;
    edge_en     = 1'b0;
    edge_clr    = 1'b0;
    bit_inc     = 1'b0;
    bit_clr     = 1'b0;
    Dat_Samp_En = 1'b0;
    Strt_Chk_En = 1'b0;
    Par_Chk_En  = 1'b0;
    Stp_Chk_En  = 1'b0;
    Deser_En    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Counters are held at zero; a low line in this very cycle starts a
        // frame, which gives back-to-back frames one cycle of slack.
        edge_clr = 1'b1;
        bit_clr  = 1'b1;
        if (!RX_IN) state_d = START;
      end

      START: begin
        Dat_Samp_En = 1'b1;
        Strt_Chk_En = 1'b1;
        edge_en     = 1'b1;
        if (edge_last) state_d = Strt_Glitch ? IDLE : DATA;
      end

      DATA: begin
        Dat_Samp_En = 1'b1;
        edge_en     = 1'b1;
        Deser_En    = (Edge_Cnt == sample_pt);
        if (edge_last) begin
          bit_inc = 1'b1;
          if (bit_last) state_d = par_en_q ? PARITY : STOP;
        end
      end

      PARITY: begin
        Dat_Samp_En = 1'b1;
        Par_Chk_En  = 1'b1;
        edge_en     = 1'b1;
        if (edge_last) state_d = STOP;
      end

      STOP: begin
        Dat_Samp_En = 1'b1;
        Stp_Chk_En  = 1'b1;
        edge_en     = 1'b1;
        if (edge_last) state_d = IDLE;
      end

      default: begin
        state_d  = IDLE;
        edge_clr = 1'b1;
        bit_clr  = 1'b1;
      end
    endcase

    // Every entry into IDLE or START restarts the edge count.
    if ((state_d != state_q) && ((state_d == IDLE) || (state_d == START))) begin
      edge_clr = 1'b1;
    end
  end

  // Frame-scoped flags: latched parity mode, parity error, valid and busy.
  always_comb begin
    par_en_d = par_en_q;
    err_d    = err_q;

    if (state_q == START) begin
      par_en_d = PAR_EN;
      err_d    = 1'b0;
    end else if ((state_q == PARITY) && edge_last) begin
      err_d = Par_Err;
    end

    // A parity error does not shorten the frame; it only suppresses the valid.
    dv_d   = (state_q == STOP) && edge_last && !err_q && !Stp_Err;
    busy_d = (state_q != IDLE);
  end

  // State and flag registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      par_en_q <= 1'b0;
      err_q    <= 1'b0;
      dv_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      par_en_q <= par_en_d;
      err_q    <= err_d;
      dv_q     <= dv_d;
      busy_q   <= busy_d;
    end
  end

  assign Data_Valid = dv_q;
  assign Busy       = busy_q;
  assign State_Dbg  = state_q;

endmodule
